// File: rtl/ternary_weight_loader.sv
// Ternary weight loader: fills an addressed row buffer over valid/ready.
// Illegal ternary codes are zeroed and flagged; done marks a full buffer.
module ternary_weight_loader #(
  parameter int MAX_IN_LEN  = 8,
  parameter int MAX_OUT_LEN = 4,
  parameter int WIDTH       = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load_start,
  input  logic [$clog2(MAX_OUT_LEN+1)-1:0] out_len,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH*MAX_IN_LEN-1:0] ui_input,
  output logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] uo_weights,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int ROW_W = WIDTH * MAX_IN_LEN;
  localparam int LEN_W = $clog2(MAX_OUT_LEN + 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_OUT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  logic [LEN_W-1:0] row_cnt;
  logic [LEN_W-1:0] len_q;
  logic [ROW_W-1:0] rows [MAX_OUT_LEN];
  logic [ROW_W-1:0] clean;
  logic illegal;
  logic beat;

  generate
    if (WIDTH == 2) begin : g_tern
      always_comb begin
        clean = ui_input;
        illegal = 1'b0;
        for (int e = 0; e < MAX_IN_LEN; e++) begin
          if (ui_input[e*2 +: 2] == 2'b10) begin
            clean[e*2 +: 2] = 2'b00;
            illegal = 1'b1;
          end
        end
      end
    end else begin : g_raw
      assign clean = ui_input;
      assign illegal = 1'b0;
    end
  endgenerate

  for (genvar r = 0; r < MAX_OUT_LEN; r++) begin : g_flat
    assign uo_weights[r*ROW_W +: ROW_W] = rows[r];
  end

  assign in_ready = ena && (state == LOAD);
  assign beat = in_valid && in_ready;
  assign busy = (state == LOAD);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      row_cnt <= '0;
      len_q <= '0;
      err <= 1'b0;
      for (int r = 0; r < MAX_OUT_LEN; r++)
        rows[r] <= '0;
    end else if (ena) begin
      if (load_start) begin
        // A restart wins over a same-cycle beat and clears the buffer.
        state <= LOAD;
        row_cnt <= '0;
        err <= 1'b0;
        for (int r = 0; r < MAX_OUT_LEN; r++)
          rows[r] <= '0;
        if (out_len == '0 || out_len > MAX_LEN)
          len_q <= MAX_LEN;
        else
          len_q <= out_len;
      end else if (beat) begin
        for (int r = 0; r < MAX_OUT_LEN; r++)
          if (row_cnt == LEN_W'(r))
            rows[r] <= clean;
        err <= err | illegal;
        row_cnt <= row_cnt + ONE;
        if (row_cnt == len_q - ONE)
          state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Randomized bench for ternary_weight_loader with a scoreboard on done
// and a per-cycle monitor against a row-list reference model.
module tb_ternary_weight_loader;

  localparam int IN = 8;
  localparam int OUT = 4;
  localparam int W = 2;
  localparam int RW = W * IN;
  localparam int LW = $clog2(OUT + 1);

  logic clk = 1'b0;
  logic rst_n, ena, load_start, in_valid;
  logic [LW-1:0] out_len;
  logic [RW-1:0] ui_input;
  logic in_ready, busy, done, err;
  logic [RW*OUT-1:0] uo_weights;

  ternary_weight_loader #(
    .MAX_IN_LEN(IN), .MAX_OUT_LEN(OUT), .WIDTH(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_start(load_start), .out_len(out_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .ui_input(ui_input), .uo_weights(uo_weights),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [RW*OUT-1:0] w;
    logic e;
  } exp_t;
  exp_t sb[$];

  bit m_load, m_done, m_err;
  int m_cnt, m_len;
  logic [RW-1:0] m_rows [OUT];
  bit started = 0;
  bit done_q = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW*OUT-1:0] flat();
    logic [RW*OUT-1:0] w = '0;
    for (int r = 0; r < OUT; r++)
      w = w | ((RW*OUT)'(m_rows[r]) << (RW * r));
    return w;
  endfunction

  // Decode each 2-bit element numerically; code 2 is not a ternary value.
  function automatic logic [RW-1:0] scrub(input logic [RW-1:0] d,
                                          output bit bad);
    int code;
    logic [RW-1:0] res = '0;
    bad = 0;
    for (int e = 0; e < IN; e++) begin
      code = int'((d >> (2 * e)) & RW'(3));
      if (code == 2) bad = 1;
      else res = res | (RW'(code) << (2 * e));
    end
    return res;
  endfunction

  task automatic model_edge();
    bit bad;
    logic [RW-1:0] c;
    if (!rst_n) begin
      m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_len = 0;
      for (int r = 0; r < OUT; r++) m_rows[r] = '0;
    end else if (ena) begin
      if (load_start) begin
        m_load = 1; m_done = 0; m_err = 0; m_cnt = 0;
        for (int r = 0; r < OUT; r++) m_rows[r] = '0;
        m_len = (out_len == 0 || int'(out_len) > OUT) ? OUT : int'(out_len);
      end else if (m_load && in_valid) begin
        c = scrub(ui_input, bad);
        m_rows[m_cnt] = c;
        if (bad) m_err = 1;
        m_cnt++;
        if (m_cnt == m_len) begin
          m_load = 0;
          m_done = 1;
          sb.push_back('{w: flat(), e: m_err});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (started) begin
      chk("busy", 64'(busy), 64'(m_load));
      chk("done", 64'(done), 64'(m_done));
      chk("in_ready", 64'(in_ready), 64'(ena && m_load));
      chk("err", 64'(err), 64'(m_err));
      chk("weights", uo_weights, flat());
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 64'(1), 64'(0));
        end else begin
          x = sb.pop_front();
          chk("sb_weights", uo_weights, x.w);
          chk("sb_err", 64'(err), 64'(x.e));
        end
      end
      done_q = done;
    end
  end

  task automatic start(input int len);
    load_start = 1; out_len = LW'(len); in_valid = 0;
    tick();
    load_start = 0;
  endtask

  task automatic row(input logic [RW-1:0] d);
    in_valid = 1; ui_input = d;
    tick();
    in_valid = 0;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] d = '0;
    int p;
    for (int e = 0; e < IN; e++) begin
      p = $urandom_range(0, 15);
      d = d | (RW'(p == 0 ? 2 : (p < 6 ? 0 : (p < 11 ? 1 : 3))) << (2 * e));
    end
    return d;
  endfunction

  initial begin
    rst_n = 0; ena = 1; load_start = 0; in_valid = 1;
    out_len = '0; ui_input = 16'h5555;
    tick();
    started = 1;
    tick();
    rst_n = 1;
    tick(); tick();
    chk("idle_weights", uo_weights, 64'h0);
    chk("idle_ready", 64'(in_ready), 64'(0));
    in_valid = 0;

    start(4);
    row(16'h0001); row(16'h0004); row(16'h0010); row(16'h0040);
    chk("full_done", 64'(done), 64'(1));
    chk("full_w", uo_weights, 64'h0040_0010_0004_0001);
    tick();

    start(2);
    row(16'h0005);
    tick();
    chk("partial_busy", 64'(busy), 64'(1));
    row(16'h00F0);
    chk("partial_w", uo_weights, 64'h0000_0000_00F0_0005);
    chk("partial_done", 64'(done), 64'(1));
    row(16'h1111);
    chk("partial_hold", uo_weights, 64'h0000_0000_00F0_0005);

    start(0);
    for (int i = 0; i < 3; i++) row(rand_row());
    chk("len0_busy", 64'(busy), 64'(1));
    row(16'h0101);
    chk("len0_done", 64'(done), 64'(1));

    start(1);
    row(16'h0002);
    chk("illegal_err", 64'(err), 64'(1));
    chk("illegal_w", uo_weights, 64'h0);
    start(3);
    chk("restart_err", 64'(err), 64'(0));

    row(16'h0011); row(16'h0033);
    load_start = 1; out_len = 3'd4; in_valid = 1; ui_input = 16'h1111;
    tick();
    load_start = 0; in_valid = 0;
    chk("prio_clear", uo_weights, 64'h0);
    row(16'h0015);
    chk("prio_row0", uo_weights, 64'h0000_0000_0000_0015);

    ena = 0; in_valid = 1; ui_input = 16'h0404;
    tick(); tick(); tick();
    chk("ena_hold", uo_weights, 64'h0000_0000_0000_0015);
    ena = 1; in_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_w", uo_weights, 64'h0);
    chk("rst_busy", 64'(busy), 64'(0));

    for (int s = 0; s < 40; s++) begin
      start($urandom_range(0, 7));
      for (int c = 0; c < 16; c++) begin
        ena = ($urandom_range(0, 9) != 0);
        load_start = ($urandom_range(0, 29) == 0);
        out_len = LW'($urandom_range(0, 7));
        in_valid = ($urandom_range(0, 3) != 0);
        ui_input = rand_row();
        tick();
      end
      ena = 1; load_start = 0; in_valid = 0;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 0;
        tick();
        rst_n = 1;
      end
    end
    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
